// File: rtl/scalar_lane_pkg.sv
// Shared types and helpers for the scalar lane sequencer.
package scalar_lane_pkg;

    typedef enum logic {MODE_SELECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_e;

    // Beats a request produces: SELECT is always one, SCAN count 0 stands for a full vector.
    function automatic logic [31:0] eff_count(input logic is_scan, input logic [31:0] cnt,
                                              input int unsigned lanes);
        if (!is_scan)
            return 32'd1;
        else if (cnt == 32'd0)
            return lanes;
        else
            return cnt;
    endfunction

endpackage

// File: rtl/scalar_lane_mux.sv
// LANES:1 lane select; an index with no matching lane yields zero.
module scalar_lane_mux #(
    parameter int N     = 32,
    parameter int LANES = 16,
    parameter int SEL_W = $clog2(LANES) + 1
) (
    input  logic [LANES*N-1:0] i_vec,
    input  logic [SEL_W-1:0]   i_idx,
    output logic [N-1:0]       o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_idx == SEL_W'(i))
                o_data = i_vec[i*N +: N];
        end
    end

endmodule

// File: rtl/scalar_lane_sequencer.sv
// Captures a vector register and streams selected lanes (single lane or a wrapping run).
module scalar_lane_sequencer
    import scalar_lane_pkg::*;
#(
    parameter int N     = 32,
    parameter int LANES = 16,
    parameter int SEL_W = $clog2(LANES) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [SEL_W-1:0]   count,
    input  logic [LANES*N-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic [SEL_W-1:0]   out_lane,
    output logic               out_last,
    output logic               out_err
);

    localparam logic [SEL_W-1:0] LANES_V = SEL_W'(LANES);

    state_e             r_state;
    logic [LANES*N-1:0] r_vec;
    logic [SEL_W-1:0]   r_rem;
    logic               r_out_valid;
    logic [N-1:0]       r_out_data;
    logic [SEL_W-1:0]   r_out_lane;
    logic               r_out_last;
    logic               r_out_err;

    logic               w_idle;
    logic [SEL_W-1:0]   w_next_lane;
    logic [LANES*N-1:0] w_mux_vec;
    logic [SEL_W-1:0]   w_mux_idx;
    logic [N-1:0]       w_mux_data;
    logic               w_req_err;
    logic [SEL_W-1:0]   w_eff;
    mode_e              w_mode;

    assign w_idle   = (r_state == ST_IDLE);
    assign in_ready = w_idle;
    assign w_mode   = mode_e'(mode);

    // Power-of-two LANES: wrapping is just dropping the carry out of the low bits.
    assign w_next_lane = {1'b0, r_out_lane[SEL_W-2:0] + (SEL_W-1)'(1)};

    // At accept the first beat comes straight from data_in; afterwards from the captured copy.
    assign w_mux_vec = w_idle ? data_in : r_vec;
    assign w_mux_idx = w_idle ? sel     : w_next_lane;

    assign w_req_err = sel[SEL_W-1] | ((w_mode == MODE_SCAN) && (count > LANES_V));
    assign w_eff     = SEL_W'(eff_count(mode, 32'(count), LANES));

    scalar_lane_mux #(.N(N), .LANES(LANES), .SEL_W(SEL_W)) u_mux (
        .i_vec  (w_mux_vec),
        .i_idx  (w_mux_idx),
        .o_data (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_vec       <= data_in;
                        r_out_valid <= 1'b1;
                        r_out_lane  <= sel;
                        r_state     <= ST_EMIT;
                        if (w_req_err) begin
                            r_rem      <= SEL_W'(1);
                            r_out_data <= '0;
                            r_out_last <= 1'b1;
                            r_out_err  <= 1'b1;
                        end else begin
                            r_rem      <= w_eff;
                            r_out_data <= w_mux_data;
                            r_out_last <= (w_eff == SEL_W'(1));
                            r_out_err  <= 1'b0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_rem       <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rem      <= r_rem - SEL_W'(1);
                            r_out_lane <= w_next_lane;
                            r_out_data <= w_mux_data;
                            r_out_last <= (r_rem == SEL_W'(2));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_last  = r_out_last;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_scalar_lane_sequencer.sv
// Directed plus randomized checks of scalar_lane_sequencer against a beat-list model.
module tb_scalar_lane_sequencer;

    localparam int N     = 32;
    localparam int LANES = 16;
    localparam int SEL_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               mode = 1'b0;
    logic [SEL_W-1:0]   sel = '0;
    logic [SEL_W-1:0]   count = '0;
    logic [LANES*N-1:0] data_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [N-1:0]       out_data;
    logic [SEL_W-1:0]   out_lane;
    logic               out_last;
    logic               out_err;

    scalar_lane_sequencer #(.N(N), .LANES(LANES), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .count(count), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           lane;
        logic         last;
        logic         err;
    } beat_t;

    beat_t expq[$];
    int total = 0;
    int bad   = 0;
    logic [LANES*N-1:0] base_vec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*N-1:0] rand_vec();
        logic [LANES*N-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*N +: N] = $urandom;
        return v;
    endfunction

    // Expected beat list straight from the request rules.
    task automatic build(input bit m, input int s, input int c, input logic [LANES*N-1:0] v);
        beat_t b;
        int    n;
        expq.delete();
        if (s >= LANES || (m && c > LANES)) begin
            b.data = '0; b.lane = s; b.last = 1'b1; b.err = 1'b1;
            expq.push_back(b);
        end else begin
            n = !m ? 1 : (c == 0 ? LANES : c);
            for (int k = 0; k < n; k++) begin
                b.lane = (s + k) % LANES;
                b.data = v[b.lane*N +: N];
                b.last = (k == n - 1);
                b.err  = 1'b0;
                expq.push_back(b);
            end
        end
    endtask

    // bp: 0 = always ready, 1 = random ready, 2 = stall beat 1 for three cycles
    task automatic run_req(input bit m, input int s, input int c, input logic [LANES*N-1:0] v,
                           input int bp, input string tag);
        int   idx = 0;
        int   cyc = 0;
        int   stall = 0;
        logic rdy;
        build(m, s, c, v);
        chk({tag, " idle_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; mode = m; sel = SEL_W'(s); count = SEL_W'(c); data_in = v;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
        data_in  = rand_vec();
        while (idx < expq.size() && cyc < 300) begin
            if (bp == 0) rdy = 1'b1;
            else if (bp == 1) rdy = 1'($urandom_range(0, 1));
            else if (idx == 1 && stall < 3) begin rdy = 1'b0; stall++; end
            else rdy = 1'b1;
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, 31));
            mode      = 1'($urandom_range(0, 1));
            chk({tag, " valid"},    64'(out_valid), 64'd1);
            chk({tag, " in_ready"}, 64'(in_ready),  64'd0);
            chk({tag, " data"},     64'(out_data),  64'(expq[idx].data));
            chk({tag, " lane"},     64'(out_lane),  64'(expq[idx].lane));
            chk({tag, " last"},     64'(out_last),  64'(expq[idx].last));
            chk({tag, " err"},      64'(out_err),   64'(expq[idx].err));
            if (rdy) idx++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, " beats_done"}, 64'(idx), 64'(expq.size()));
        chk({tag, " end_valid"},  64'(out_valid), 64'd0);
        chk({tag, " end_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) base_vec[i*N +: N] = 32'hA000_0000 + i;

        #2;
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data",  64'(out_data),  64'd0);
        chk("rst out_lane",  64'(out_lane),  64'd0);
        chk("rst out_last",  64'(out_last),  64'd0);
        chk("rst out_err",   64'(out_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_req(1'b0, 5,  0,  base_vec, 0, "sel5");
        run_req(1'b1, 3,  4,  base_vec, 0, "scan3x4");
        run_req(1'b1, 14, 4,  base_vec, 0, "scan_wrap");
        run_req(1'b1, 0,  0,  base_vec, 0, "scan_full");
        run_req(1'b0, 16, 0,  base_vec, 0, "sel_oor");
        run_req(1'b1, 2,  17, base_vec, 0, "scan_cnt_oor");
        run_req(1'b1, 0,  3,  base_vec, 2, "backpressure");

        // Reset in the middle of an 8-beat scan, after two beats have gone out.
        in_valid = 1'b1; mode = 1'b1; sel = '0; count = SEL_W'(8); data_in = base_vec;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid lane2", 64'(out_lane), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst valid",    64'(out_valid), 64'd0);
        chk("mid rst in_ready", 64'(in_ready),  64'd1);
        chk("mid rst data",     64'(out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post rst idle", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
        run_req(1'b0, 9, 0, base_vec, 0, "after_rst_sel9");

        for (int t = 0; t < 40; t++) begin
            int s;
            int c;
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 20));
            run_req(1'($urandom_range(0, 1)), s, c, rand_vec(), int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
